// File: rtl/ofm_in_fsm_v2.sv
// TX ingress FSM: takes one txc control packet, then one txd frame. Data beats go to the data FIFO.
// One checksum-offload descriptor per forwarded frame goes to the control FIFO.
module ofm_in_fsm_v2 #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_DROP_BAD   = 1,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic                                  mm2s_clk,
  input  logic                                  mm2s_reset,
  input  logic [C_DATA_WIDTH-1:0]               txd_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]             txd_tkeep,
  input  logic                                  txd_tvalid,
  input  logic                                  txd_tlast,
  output logic                                  txd_tready,
  input  logic [31:0]                           txc_tdata,
  input  logic [3:0]                            txc_tkeep,
  input  logic                                  txc_tvalid,
  input  logic                                  txc_tlast,
  output logic                                  txc_tready,
  input  logic                                  ctrl_fifo_afull,
  output logic [63:0]                           ctrl_fifo_wdata,
  output logic                                  ctrl_fifo_wren,
  input  logic                                  data_fifo_afull,
  output logic [C_DATA_WIDTH+C_DATA_WIDTH/8:0]  data_fifo_wdata,
  output logic                                  data_fifo_wren,
  output logic [C_CNT_WIDTH-1:0]                drop_cnt,
  output logic [3:0]                            ofm_in_fsm_dbg
);

  localparam int K  = C_DATA_WIDTH / 8;
  localparam int PW = $clog2(K + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CTRL = 3'd1,
    S_WAIT = 3'd2,
    S_DATA = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic                           ctrl_afull_q, data_afull_q;
  logic [2:0]                     wcnt_q;
  logic                           tx_ok_q;
  logic [1:0]                     cs_cntrl_q;
  logic [15:0]                    cs_begin_q, cs_insert_q, cs_init_q;
  logic [13:0]                    bcnt_q, bcnt_d;
  logic [14:0]                    bcnt_sum;
  logic [PW-1:0]                  keep_cnt;
  logic [C_CNT_WIDTH-1:0]         drop_cnt_q;
  logic [63:0]                    ctrl_wdata_q;
  logic                           ctrl_wren_q, data_wren_q;
  logic [C_DATA_WIDTH+K:0]        data_wdata_q;
  logic                           ctrl_word, data_beat, drop_last;
  logic                           unused_ok;

  assign unused_ok = ^txc_tkeep;

  always_comb begin
    state_d    = state_q;
    txc_tready = 1'b0;
    txd_tready = 1'b0;
    case (state_q)
      S_IDLE: if (txc_tvalid && !ctrl_afull_q) state_d = S_CTRL;
      S_CTRL: begin
        txc_tready = 1'b1;
        if (txc_tvalid && txc_tlast) state_d = S_WAIT;
      end
      S_WAIT: begin
        if ((C_DROP_BAD != 0) && !tx_ok_q && txd_tvalid) state_d = S_DROP;
        else if (txd_tvalid && !data_afull_q)            state_d = S_DATA;
      end
      S_DATA, S_DROP: begin
        txd_tready = 1'b1;
        if (txd_tvalid && txd_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < K; i++) keep_cnt = keep_cnt + PW'(txd_tkeep[i]);
  end

  // Byte count saturates at 14 bits; the sum includes the beat being accepted so the descriptor sees it.
  assign bcnt_sum  = {1'b0, bcnt_q} + 15'(keep_cnt);
  assign bcnt_d    = bcnt_sum[14] ? 14'h3FFF : bcnt_sum[13:0];
  assign ctrl_word = (state_q == S_CTRL) && txc_tvalid;
  assign data_beat = (state_q == S_DATA) && txd_tvalid;
  assign drop_last = (state_q == S_DROP) && txd_tvalid && txd_tlast;

  always_ff @(posedge mm2s_clk or posedge mm2s_reset) begin
    if (mm2s_reset) begin
      state_q      <= S_IDLE;
      ctrl_afull_q <= 1'b0;
      data_afull_q <= 1'b0;
      wcnt_q       <= '0;
      tx_ok_q      <= 1'b0;
      cs_cntrl_q   <= '0;
      cs_begin_q   <= '0;
      cs_insert_q  <= '0;
      cs_init_q    <= '0;
      bcnt_q       <= '0;
      drop_cnt_q   <= '0;
      ctrl_wdata_q <= '0;
      ctrl_wren_q  <= 1'b0;
      data_wdata_q <= '0;
      data_wren_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_afull_q <= ctrl_fifo_afull;
      data_afull_q <= data_fifo_afull;
      data_wren_q  <= data_beat;
      ctrl_wren_q  <= data_beat && txd_tlast;
      if (data_beat) data_wdata_q <= {txd_tlast, txd_tkeep, txd_tdata};
      if (drop_last && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (state_q == S_IDLE) begin
        wcnt_q      <= '0;
        tx_ok_q     <= 1'b0;
        cs_cntrl_q  <= '0;
        cs_begin_q  <= '0;
        cs_insert_q <= '0;
        cs_init_q   <= '0;
        bcnt_q      <= '0;
      end else begin
        if (ctrl_word) begin
          if (wcnt_q != 3'd7) wcnt_q <= wcnt_q + 3'd1;
          case (wcnt_q)
            3'd0: tx_ok_q <= (txc_tdata[31:28] == 4'b1000);
            3'd1: cs_cntrl_q <= txc_tdata[1:0];
            3'd2: begin
              cs_begin_q  <= txc_tdata[31:16];
              cs_insert_q <= txc_tdata[15:0];
            end
            3'd3: cs_init_q <= txc_tdata[15:0];
            default: ;
          endcase
        end
        if (data_beat) begin
          bcnt_q <= bcnt_d;
          if (txd_tlast) ctrl_wdata_q <= {bcnt_d, cs_cntrl_q, cs_init_q, cs_insert_q, cs_begin_q};
        end
      end
    end
  end

  assign ctrl_fifo_wdata = ctrl_wdata_q;
  assign ctrl_fifo_wren  = ctrl_wren_q;
  assign data_fifo_wdata = data_wdata_q;
  assign data_fifo_wren  = data_wren_q;
  assign drop_cnt        = drop_cnt_q;
  assign ofm_in_fsm_dbg  = {1'b0, state_q};

endmodule

// File: tb/tb_ofm_in_fsm_v2.sv
// Directed bench for ofm_in_fsm_v2: a 64-bit instance with a 2-bit drop counter, plus a 128-bit
// instance used for byte-count saturation. Expected values are hand-computed constants.
module tb_ofm_in_fsm_v2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  txc_tdata = '0;
  logic [3:0]   txc_tkeep = 4'hF;
  logic         txc_tvalid = 1'b0, txc_tlast = 1'b0;
  logic         ctrl_afull = 1'b0, data_afull = 1'b0;

  logic [63:0]  d64_tdata = '0;
  logic [7:0]   d64_tkeep = '0;
  logic         d64_tvalid = 1'b0, d64_tlast = 1'b0;
  logic         d64_txd_rdy, d64_txc_rdy, d64_cwren, d64_dwren;
  logic [63:0]  d64_cwdata;
  logic [72:0]  d64_dwdata;
  logic [1:0]   d64_drop;
  logic [3:0]   d64_dbg;

  logic [127:0] d128_tdata = '0;
  logic [15:0]  d128_tkeep = '0;
  logic         d128_tvalid = 1'b0, d128_tlast = 1'b0;
  logic         d128_txd_rdy, d128_txc_rdy, d128_cwren, d128_dwren;
  logic [63:0]  d128_cwdata;
  logic [144:0] d128_dwdata;
  logic [15:0]  d128_drop;
  logic [3:0]   d128_dbg;

  int checks = 0, errors = 0;
  int n_dwr = 0, n_cwr = 0, n_both = 0, n_dwr128 = 0;
  logic [63:0] desc64 = '0, desc128 = '0;
  logic [72:0] last_dw64 = '0;

  always #5 clk = ~clk;

  ofm_in_fsm_v2 #(.C_DATA_WIDTH(64), .C_DROP_BAD(1), .C_CNT_WIDTH(2)) dut64 (
    .mm2s_clk(clk), .mm2s_reset(rst),
    .txd_tdata(d64_tdata), .txd_tkeep(d64_tkeep), .txd_tvalid(d64_tvalid), .txd_tlast(d64_tlast),
    .txd_tready(d64_txd_rdy),
    .txc_tdata(txc_tdata), .txc_tkeep(txc_tkeep), .txc_tvalid(txc_tvalid), .txc_tlast(txc_tlast),
    .txc_tready(d64_txc_rdy),
    .ctrl_fifo_afull(ctrl_afull), .ctrl_fifo_wdata(d64_cwdata), .ctrl_fifo_wren(d64_cwren),
    .data_fifo_afull(data_afull), .data_fifo_wdata(d64_dwdata), .data_fifo_wren(d64_dwren),
    .drop_cnt(d64_drop), .ofm_in_fsm_dbg(d64_dbg)
  );

  ofm_in_fsm_v2 #(.C_DATA_WIDTH(128), .C_DROP_BAD(1), .C_CNT_WIDTH(16)) dut128 (
    .mm2s_clk(clk), .mm2s_reset(rst),
    .txd_tdata(d128_tdata), .txd_tkeep(d128_tkeep), .txd_tvalid(d128_tvalid), .txd_tlast(d128_tlast),
    .txd_tready(d128_txd_rdy),
    .txc_tdata(txc_tdata), .txc_tkeep(txc_tkeep), .txc_tvalid(txc_tvalid), .txc_tlast(txc_tlast),
    .txc_tready(d128_txc_rdy),
    .ctrl_fifo_afull(ctrl_afull), .ctrl_fifo_wdata(d128_cwdata), .ctrl_fifo_wren(d128_cwren),
    .data_fifo_afull(data_afull), .data_fifo_wdata(d128_dwdata), .data_fifo_wren(d128_dwren),
    .drop_cnt(d128_drop), .ofm_in_fsm_dbg(d128_dbg)
  );

  always @(negedge clk) begin
    if (d64_dwren) begin n_dwr++; last_dw64 = d64_dwdata; end
    if (d64_cwren) begin n_cwr++; desc64 = d64_cwdata; end
    if (d64_dwren && d64_cwren) n_both++;
    if (d128_dwren) n_dwr128++;
    if (d128_cwren) desc128 = d128_cwdata;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered just after a posedge; returns just after the posedge that accepted the beat/word.
  task automatic wait_acc(input int sel);
    int t = 0;
    logic rdy;
    @(negedge clk);
    forever begin
      rdy = (sel == 0) ? d64_txc_rdy : (sel == 1) ? d64_txd_rdy : d128_txd_rdy;
      if (rdy) break;
      t++;
      if (t > 50) begin
        check("accept_timeout", 160'(t), 160'(0));
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_ctrl(input logic [31:0] w0, w1, w2, w3, w4, input int n);
    logic [31:0] w [5];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
    for (int i = 0; i < n; i++) begin
      txc_tdata = w[i]; txc_tlast = (i == n - 1); txc_tvalid = 1'b1;
      wait_acc(0);
    end
    txc_tvalid = 1'b0; txc_tlast = 1'b0;
  endtask

  task automatic send_data64(input int n, input logic [7:0] lk, input int abort_at);
    for (int i = 0; i < n; i++) begin
      d64_tdata = {32'hA5A5_5A5A, 32'(i)};
      d64_tkeep = (i == n - 1) ? lk : 8'hFF;
      d64_tlast = (i == n - 1);
      d64_tvalid = 1'b1;
      if (i == abort_at) begin
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        break;
      end
      wait_acc(1);
    end
    d64_tvalid = 1'b0; d64_tlast = 1'b0;
  endtask

  task automatic send_data128(input int n);
    for (int i = 0; i < n; i++) begin
      d128_tdata = 128'(i); d128_tkeep = 16'hFFFF; d128_tlast = (i == n - 1); d128_tvalid = 1'b1;
      wait_acc(2);
    end
    d128_tvalid = 1'b0; d128_tlast = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  int bd, bc, bb;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dbg", 160'(d64_dbg), 160'(0));
    check("rst_wren", 160'({d64_cwren, d64_dwren}), 160'(0));
    check("rst_wdata", 160'({d64_cwdata, d64_dwdata}), 160'(0));
    check("rst_drop", 160'(d64_drop), 160'(0));
    check("rst_txc_rdy", 160'(d64_txc_rdy), 160'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 8 full beats, last keep 0x0F -> 60 bytes
    bd = n_dwr; bc = n_cwr; bb = n_both;
    send_ctrl(32'h8000_0000, 32'h0000_0002, 32'h000E_0028, 32'h0000_1234, 32'h0, 4);
    send_data64(8, 8'h0F, -1);
    settle();
    check("t1_dwr", 160'(n_dwr - bd), 160'(8));
    check("t1_cwr", 160'(n_cwr - bc), 160'(1));
    check("t1_desc", 160'(desc64), 160'({14'd60, 2'b10, 16'h1234, 16'h0028, 16'h000E}));
    check("t1_last_data", 160'(last_dw64), 160'({1'b1, 8'h0F, 64'hA5A5_5A5A_0000_0007}));
    check("t1_both", 160'(n_both - bb), 160'(1));
    check("t1_drop", 160'(d64_drop), 160'(0));
    check("t1_idle", 160'(d64_dbg), 160'(0));
    $display("txn 1: good 8-beat frame desc=%h", desc64);

    // 2: invalid flag dropped, then good frame (2 beats, 8+2 bytes)
    bd = n_dwr; bc = n_cwr;
    send_ctrl(32'h4000_0000, 32'h1, 32'h0010_0020, 32'hABCD, 32'h0, 4);
    send_data64(3, 8'hFF, -1);
    settle();
    check("t2_drop_dwr", 160'(n_dwr - bd), 160'(0));
    check("t2_drop_cwr", 160'(n_cwr - bc), 160'(0));
    check("t2_drop_cnt", 160'(d64_drop), 160'(1));
    send_ctrl(32'h8000_0000, 32'h1, 32'h0010_0020, 32'hABCD, 32'h0, 4);
    send_data64(2, 8'h03, -1);
    settle();
    check("t2_good_dwr", 160'(n_dwr - bd), 160'(2));
    check("t2_good_desc", 160'(desc64), 160'({14'd10, 2'b01, 16'hABCD, 16'h0020, 16'h0010}));
    $display("txn 2: dropped bad frame, drop_cnt=%0d, then desc=%h", d64_drop, desc64);

    // 3: ctrl afull holds IDLE; data afull mid-frame does not stall
    ctrl_afull = 1'b1;
    repeat (2) @(posedge clk);
    #1 txc_tdata = 32'h8000_0000; txc_tlast = 1'b0; txc_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_afull_hold", 160'({d64_txc_rdy, d64_dbg}), 160'(0));
    @(posedge clk); #1 ctrl_afull = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_afull_lag", 160'(d64_txc_rdy), 160'(0));
    @(negedge clk);
    check("t3_ctrl_entry", 160'(d64_dbg), 160'(1));
    txc_tvalid = 1'b0;
    @(posedge clk); #1;
    bd = n_dwr;
    send_ctrl(32'h8000_0000, 32'h3, 32'h0004_0008, 32'h5555, 32'h0, 4);
    fork
      send_data64(6, 8'hFF, -1);
      begin repeat (3) @(posedge clk); #1 data_afull = 1'b1; end
    join
    settle();
    data_afull = 1'b0;
    check("t3_dwr", 160'(n_dwr - bd), 160'(6));
    check("t3_desc", 160'(desc64), 160'({14'd48, 2'b11, 16'h5555, 16'h0008, 16'h0004}));
    $display("txn 3: afull gating, desc=%h", desc64);

    // 4: 2-word packet, single beat keep 0x01
    bd = n_dwr; bb = n_both;
    send_ctrl(32'h8000_0000, 32'h1, 32'h0, 32'h0, 32'h0, 2);
    send_data64(1, 8'h01, -1);
    settle();
    check("t4_dwr", 160'(n_dwr - bd), 160'(1));
    check("t4_both", 160'(n_both - bb), 160'(1));
    check("t4_desc", 160'(desc64), 160'({14'd1, 2'b01, 16'h0, 16'h0, 16'h0}));
    $display("txn 4: short packet single beat desc=%h", desc64);

    // 5: reset on the third data beat
    bd = n_dwr; bc = n_cwr;
    send_ctrl(32'h8000_0000, 32'h2, 32'h1111_2222, 32'h3333, 32'h0, 4);
    send_data64(8, 8'hFF, 2);
    #1;
    check("t5_dbg", 160'(d64_dbg), 160'(0));
    check("t5_wren", 160'({d64_cwren, d64_dwren}), 160'(0));
    check("t5_wdata", 160'({d64_cwdata, d64_dwdata}), 160'(0));
    check("t5_drop", 160'(d64_drop), 160'(0));
    @(posedge clk); #1;
    settle();
    check("t5_dwr", 160'(n_dwr - bd), 160'(2));
    check("t5_cwr", 160'(n_cwr - bc), 160'(0));
    send_ctrl(32'h8000_0000, 32'h2, 32'h0006_0009, 32'h00AA, 32'h0, 4);
    send_data64(2, 8'h0F, -1);
    settle();
    check("t5_after_desc", 160'(desc64), 160'({14'd12, 2'b10, 16'h00AA, 16'h0009, 16'h0006}));
    $display("txn 5: reset mid-frame, next desc=%h", desc64);

    // 6a: 2-bit drop counter saturates at 3
    bd = n_dwr; bc = n_cwr;
    for (int f = 0; f < 4; f++) begin
      send_ctrl(32'h0000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 1);
      send_data64(1, 8'hFF, -1);
      settle();
      if (f == 2) check("t6_drop3", 160'(d64_drop), 160'(3));
    end
    check("t6_drop_sat", 160'(d64_drop), 160'(3));
    check("t6_drop_nowr", 160'({n_dwr - bd, n_cwr - bc}), 160'(0));
    $display("txn 6a: drop_cnt saturated at %0d", d64_drop);

    // 6b: 128-bit, 1100 full beats -> bcnt saturates; word 4 ignored
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    send_ctrl(32'h8000_0000, 32'h0, 32'h0003_0007, 32'h0009, 32'hFFFF_FFFF, 5);
    send_data128(1100);
    settle();
    check("t6_dwr128", 160'(n_dwr128), 160'(1100));
    check("t6_desc128", 160'(desc128), 160'({14'h3FFF, 2'b00, 16'h0009, 16'h0007, 16'h0003}));
    $display("txn 6b: 128-bit saturating bcnt desc=%h", desc128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
